// File: rtl/blk130_pkg.sv
// Shared constants and FSM encoding for the 128b/130b block sequencer.
// Sync headers, scrambler controls and ordered-set symbols live here so checkers can reuse them.
package blk130_pkg;

   localparam logic [1:0] SYNC_DATA = 2'b10;
   localparam logic [1:0] SYNC_OS   = 2'b01;

   localparam logic [1:0] ES_BYPASS = 2'b00;
   localparam logic [1:0] ES_SCRAM  = 2'b01;
   localparam logic [1:0] ES_RESEED = 2'b11;

   localparam logic [7:0] SKP_SYM = 8'hAA;
   localparam logic [7:0] SKP_END = 8'hE1;
   localparam logic [7:0] EDS_SYM = 8'h1F;
   localparam logic [7:0] EIE_LO  = 8'h00;
   localparam logic [7:0] EIE_HI  = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_DATA = 3'd2,
      ST_OS   = 3'd3,
      ST_SKP  = 3'd4
   } state_e;

endpackage

// File: rtl/blk_seq_128b130b_skp_sched.sv
// Counts completed data blocks and flags when a SKP ordered set is owed.
// The count saturates at the interval so a due SKP stays pending until cleared.
module skp_sched #(
   parameter int unsigned SKP_INTERVAL = 370,
   parameter int unsigned CNT_W        = 9
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic due
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(SKP_INTERVAL);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign due = (cnt_q == LIMIT);

endmodule

// File: rtl/blk_seq_128b130b.sv
// 128b/130b transmit block sequencer: frames DLL bytes into blocks, inserts SKP and
// ordered-set blocks, and steers the downstream scrambler via en_scram.
module blk_seq_128b130b
   import blk130_pkg::*;
#(
   parameter int unsigned BLK_BYTES    = 16,
   parameter int unsigned SKP_INTERVAL = 370,
   parameter int unsigned CNT_W        = 9
) (
   input  logic       clk_1G,
   input  logic       rst_1G,
   input  logic       link_en,
   input  logic       dll_valid,
   input  logic [7:0] dll_data,
   output logic       dll_ready,
   input  logic       os_req,
   input  logic       os_type,
   output logic       os_ack,
   output logic [7:0] blk_data,
   output logic       blk_valid,
   output logic [1:0] sync_hdr,
   output logic       hdr_valid,
   output logic [1:0] en_scram,
   output logic       idle_fill,
   output logic [2:0] dbg_state
);

   localparam logic [3:0] LAST_BYTE = 4'(BLK_BYTES - 1);

   state_e     state_q, state_d;
   logic [3:0] byte_cnt_q, byte_cnt_d;
   logic       os_type_q, os_type_d;
   logic       byte_last;
   logic       skp_due, skp_inc, skp_clr;

   assign byte_last = (byte_cnt_q == LAST_BYTE);
   assign dbg_state = state_q;

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      os_type_d  = os_type_q;
      skp_inc    = 1'b0;
      skp_clr    = 1'b0;
      dll_ready  = 1'b0;
      os_ack     = 1'b0;
      blk_data   = 8'h00;
      blk_valid  = 1'b0;
      sync_hdr   = 2'b00;
      hdr_valid  = 1'b0;
      en_scram   = ES_BYPASS;
      idle_fill  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (link_en) state_d = ST_HDR;
         end
         ST_HDR: begin
            hdr_valid  = 1'b1;
            byte_cnt_d = '0;
            // A due SKP outranks a waiting ordered-set request, which then gets the next slot.
            if (skp_due) begin
               sync_hdr = SYNC_OS;
               skp_clr  = 1'b1;
               state_d  = ST_SKP;
            end else if (os_req) begin
               sync_hdr  = SYNC_OS;
               os_ack    = 1'b1;
               os_type_d = os_type;
               state_d   = ST_OS;
            end else begin
               sync_hdr = SYNC_DATA;
               state_d  = ST_DATA;
            end
         end
         ST_DATA: begin
            dll_ready = 1'b1;
            blk_valid = 1'b1;
            en_scram  = ES_SCRAM;
            skp_inc   = byte_last;
            if (dll_valid) begin
               blk_data = dll_data;
            end else begin
               idle_fill = 1'b1;
            end
         end
         ST_OS: begin
            blk_valid = 1'b1;
            if (os_type_q) begin
               blk_data = EDS_SYM;
            end else begin
               blk_data = byte_cnt_q[0] ? EIE_HI : EIE_LO;
               if (byte_last) en_scram = ES_RESEED;
            end
         end
         ST_SKP: begin
            blk_valid = 1'b1;
            blk_data  = byte_last ? SKP_END : SKP_SYM;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Body states always run to the full block length; link_en is only honoured at the end.
      if (state_q inside {ST_DATA, ST_OS, ST_SKP}) begin
         byte_cnt_d = byte_cnt_q + 4'd1;
         if (byte_last) state_d = link_en ? ST_HDR : ST_IDLE;
      end
   end

   always_ff @(posedge clk_1G or negedge rst_1G) begin
      if (!rst_1G) begin
         state_q    <= ST_IDLE;
         byte_cnt_q <= '0;
         os_type_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         os_type_q  <= os_type_d;
      end
   end

   skp_sched #(
      .SKP_INTERVAL(SKP_INTERVAL),
      .CNT_W       (CNT_W)
   ) u_skp_sched (
      .clk  (clk_1G),
      .rst_n(rst_1G),
      .inc  (skp_inc),
      .clr  (skp_clr),
      .due  (skp_due)
   );

endmodule

// File: tb/tb_blk_seq_128b130b.sv
// Directed bench for blk_seq_128b130b; a negedge monitor pops per-cycle expectations
// pushed by the stimulus tasks. Uses a short SKP interval of 4 data blocks.
module tb_blk_seq_128b130b;

  localparam int W = 17;

  logic       clk_1G;
  logic       rst_1G;
  logic       link_en;
  logic       dll_valid;
  logic [7:0] dll_data;
  logic       dll_ready;
  logic       os_req;
  logic       os_type;
  logic       os_ack;
  logic [7:0] blk_data;
  logic       blk_valid;
  logic [1:0] sync_hdr;
  logic       hdr_valid;
  logic [1:0] en_scram;
  logic       idle_fill;
  logic [2:0] dbg_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  blk_seq_128b130b #(
    .BLK_BYTES(16),
    .SKP_INTERVAL(4),
    .CNT_W(9)
  ) dut (
    .clk_1G(clk_1G),
    .rst_1G(rst_1G),
    .link_en(link_en),
    .dll_valid(dll_valid),
    .dll_data(dll_data),
    .dll_ready(dll_ready),
    .os_req(os_req),
    .os_type(os_type),
    .os_ack(os_ack),
    .blk_data(blk_data),
    .blk_valid(blk_valid),
    .sync_hdr(sync_hdr),
    .hdr_valid(hdr_valid),
    .en_scram(en_scram),
    .idle_fill(idle_fill),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk_1G = 1'b0;
    forever #5 clk_1G = ~clk_1G;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // ---------------- helpers ----------------
  // Packed layout: {dll_ready, os_ack, hdr_valid, sync_hdr, blk_valid, en_scram, idle_fill, blk_data}
  function automatic logic [W-1:0] mk(input logic rdy, input logic ack, input logic hv,
                                      input logic [1:0] sh, input logic bv,
                                      input logic [1:0] es, input logic fill,
                                      input logic [7:0] d);
    return {rdy, ack, hv, sh, bv, es, fill, d};
  endfunction

  function automatic logic [W-1:0] act_word();
    return {dll_ready, os_ack, hdr_valid, sync_hdr, blk_valid, en_scram, idle_fill, blk_data};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_1G);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_1G) begin
    if (mon_en && rst_1G) begin
      if (hdr_valid || blk_valid) begin
        if (exp_q.size() == 0) check("unexpected_out", act_word(), '0);
        else check("blk_out", act_word(), exp_q.pop_front());
      end else if (exp_q.size() != 0) begin
        check("missing_out", act_word(), exp_q.pop_front());
      end else begin
        check("idle_out", act_word(), '0);
      end
    end
  end

  // ---------------- driver tasks (entered in a header cycle) ----------------
  task automatic hdr_cycle(input logic [1:0] sh, input logic ack);
    exp_q.push_back(mk(1'b0, ack, 1'b1, sh, 1'b0, 2'b00, 1'b0, 8'h00));
    step();
  endtask

  // gap_lo..gap_hi: 1-based body bytes with dll_valid=0; os_at/drop_at: body byte to
  // raise os_req / drop link_en (0 = never); abort_at: body byte to assert reset.
  task automatic data_block(input logic [7:0] base, input int gap_lo, input int gap_hi,
                            input int os_at, input logic os_t, input int drop_at,
                            input int abort_at);
    logic [7:0] d;
    hdr_cycle(2'b10, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      if (i == abort_at) begin
        rst_1G = 1'b0;
        #1;
        check("async_rst_out", act_word(), '0);
        check("async_rst_state", {14'd0, dbg_state}, {14'd0, 3'd0});
        return;
      end
      d = base + 8'(i - 1);
      if (i == os_at) begin
        os_req  = 1'b1;
        os_type = os_t;
      end
      if (i == drop_at) link_en = 1'b0;
      if (i >= gap_lo && i <= gap_hi) begin
        dll_valid = 1'b0;
        dll_data  = 8'h5A;
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 1'b1, 8'h00));
      end else begin
        dll_valid = 1'b1;
        dll_data  = d;
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 1'b0, d));
      end
      step();
    end
    dll_valid = 1'b0;
  endtask

  task automatic os_block(input logic eds);
    logic [7:0] d;
    logic [1:0] es;
    hdr_cycle(2'b01, 1'b1);
    os_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      d  = eds ? 8'h1F : ((i % 2) == 1 ? 8'hFF : 8'h00);
      es = (!eds && i == 15) ? 2'b11 : 2'b00;
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, es, 1'b0, d));
      step();
    end
  endtask

  task automatic skp_block();
    hdr_cycle(2'b01, 1'b0);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0,
                         (i == 15) ? 8'hE1 : 8'hAA));
      step();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_1G    = 1'b0;
    link_en   = 1'b0;
    dll_valid = 1'b0;
    dll_data  = 8'h00;
    os_req    = 1'b0;
    os_type   = 1'b0;

    // Reset held, then released with the link disabled: everything stays quiet.
    repeat (5) step();
    check("reset_out", act_word(), '0);
    check("reset_state", {14'd0, dbg_state}, {14'd0, 3'd0});
    rst_1G = 1'b1;
    mon_en = 1'b1;
    repeat (3) step();
    check("idle_state", {14'd0, dbg_state}, {14'd0, 3'd0});

    // Link up: one cycle in IDLE, then the first header.
    link_en = 1'b1;
    step();
    data_block(8'h01, 0, -1, 0, 1'b0, 0, 0);        // bytes 01..10 in order
    data_block(8'h20, 5, 7, 0, 1'b0, 0, 0);         // starved on body bytes 5-7
    data_block(8'h40, 0, -1, 3, 1'b0, 0, 0);        // EIEOS request mid-block
    os_block(1'b0);                                 // EIEOS with reseed on last byte
    data_block(8'h60, 0, -1, 10, 1'b1, 0, 0);       // 4th data block; EDS request pending
    skp_block();                                    // SKP wins the boundary
    os_block(1'b1);                                 // deferred EDS follows
    data_block(8'h80, 0, -1, 0, 1'b0, 0, 0);        // counter restarted: 4 more data blocks
    data_block(8'h90, 0, -1, 0, 1'b0, 0, 0);
    data_block(8'hA0, 0, -1, 0, 1'b0, 0, 0);
    data_block(8'hB0, 0, -1, 0, 1'b0, 0, 0);
    skp_block();

    // Asynchronous reset in the middle of a data block.
    data_block(8'hC0, 0, -1, 0, 1'b0, 0, 9);
    dll_valid = 1'b0;
    step();
    check("rst_hold_out", act_word(), '0);
    exp_q.delete();
    rst_1G = 1'b1;
    #1;
    check("rst_release_state", {14'd0, dbg_state}, {14'd0, 3'd0});
    step();
    data_block(8'hD0, 0, -1, 0, 1'b0, 0, 0);        // fresh block starts with a header

    // link_en falls mid-block: block completes, then IDLE.
    data_block(8'hE0, 0, -1, 0, 1'b0, 8, 0);
    repeat (4) step();
    check("link_down_state", {14'd0, dbg_state}, {14'd0, 3'd0});
    check("queue_drained", W'(exp_q.size()), '0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
